// File: rtl/core_icache.sv
// Direct-mapped read-only instruction cache: same-cycle hits on the fetch port,
// whole-line refills over a pipelined Wishbone master, plus hit/miss counters.
module core_icache #(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    // fetch side (pipelined Wishbone slave)
    input  logic [31:0] cpu_adr_i,
    input  logic        cpu_cyc_i,
    input  logic        cpu_stb_i,
    input  logic        cpu_we_i,
    output logic [31:0] cpu_dat_o,
    output logic        cpu_ack_o,
    output logic        cpu_stall_o,
    // memory side (pipelined Wishbone master)
    output logic [31:0] mem_adr_o,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_ack_i,
    input  logic        mem_stall_i,
    // maintenance and monitoring
    input  logic        inv_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);
    localparam int WB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = 32 - IB - WB - 2;
    localparam int CW = WB + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TB-1:0]     tag_q  [LINES];
    logic [31:0]       data_q [LINES][WORDS];
    logic [31:0]       base_q, base_d;
    logic [CW-1:0]     issued_q, issued_d;
    logic [CW-1:0]     acked_q, acked_d;
    logic              poison_q, poison_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic [WB-1:0]     word_s;
    logic [IB-1:0]     idx_s;
    logic [TB-1:0]     tag_s;
    logic [IB-1:0]     fill_idx_s;
    logic [TB-1:0]     fill_tag_s;
    logic              req_s;
    logic              hit_s;
    logic              miss_s;
    logic              beat_wr_s;
    logic              last_ack_s;
    logic [LINES-1:0]  valid_set_s;
    logic              unused_s;

    assign word_s     = cpu_adr_i[WB+1:2];
    assign idx_s      = cpu_adr_i[WB+IB+1:WB+2];
    assign tag_s      = cpu_adr_i[31:WB+IB+2];
    assign fill_idx_s = base_q[WB+IB+1:WB+2];
    assign fill_tag_s = base_q[31:WB+IB+2];
    assign unused_s   = ^{cpu_we_i, cpu_adr_i[1:0]};

    // Lookups are only answered from IDLE so a line under refill is never served.
    assign req_s  = cpu_cyc_i & cpu_stb_i;
    assign hit_s  = req_s & valid_q[idx_s] & (tag_q[idx_s] == tag_s) & (state_q == IDLE);
    assign miss_s = req_s & ~hit_s & (state_q == IDLE);

    assign cpu_ack_o   = hit_s;
    assign cpu_dat_o   = data_q[idx_s][word_s];
    assign cpu_stall_o = 1'b0;

    assign mem_cyc_o = (state_q == REFILL);
    assign mem_stb_o = (state_q == REFILL) && (issued_q < CW'(WORDS));
    assign mem_adr_o = (state_q == REFILL) ? (base_q + (32'(issued_q) << 2)) : 32'd0;
    assign mem_we_o  = 1'b0;

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    // Next-state logic for the refill FSM, valid bits and counters.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issued_d    = issued_q;
        acked_d     = acked_q;
        poison_d    = poison_q;
        miss_cnt_d  = miss_cnt_q;
        hit_cnt_d   = hit_s ? (hit_cnt_q + 32'd1) : hit_cnt_q;
        beat_wr_s   = 1'b0;
        last_ack_s  = 1'b0;
        valid_set_s = {LINES{1'b0}};
        case (state_q)
            IDLE: begin
                if (miss_s) begin
                    state_d    = REFILL;
                    base_d     = {tag_s, idx_s, {(WB+2){1'b0}}};
                    issued_d   = {CW{1'b0}};
                    acked_d    = {CW{1'b0}};
                    poison_d   = 1'b0;
                    miss_cnt_d = miss_cnt_q + 32'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            REFILL: begin
                if (mem_stb_o && !mem_stall_i) begin
                    issued_d = issued_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    issued_d = issued_q;
                end
                if (mem_ack_i) begin
                    beat_wr_s = 1'b1;
                    acked_d   = acked_q + {{(CW-1){1'b0}}, 1'b1};
                    if (acked_q == CW'(WORDS - 1)) begin
                        last_ack_s  = 1'b1;
                        state_d     = DONE;
                        // A refill that saw an invalidate is written but stays invalid.
                        valid_set_s[fill_idx_s] = ~poison_q & ~inv_i;
                    end else begin
                        state_d = REFILL;
                    end
                end else begin
                    acked_d = acked_q;
                end
                poison_d = poison_q | inv_i;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = inv_i ? {LINES{1'b0}} : (valid_q | valid_set_s);
    end

    // Control state, valid bits and counters with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= {LINES{1'b0}};
            base_q     <= 32'd0;
            issued_q   <= {CW{1'b0}};
            acked_q    <= {CW{1'b0}};
            poison_q   <= 1'b0;
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            base_q     <= base_d;
            issued_q   <= issued_d;
            acked_q    <= acked_d;
            poison_q   <= poison_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag and data storage; contents are qualified by valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && beat_wr_s) begin
            data_q[fill_idx_s][acked_q[WB-1:0]] <= mem_dat_i;
        end
        if (!rst && last_ack_s) begin
            tag_q[fill_idx_s] <= fill_tag_s;
        end
    end

endmodule
